// File: rtl/bft_pkg.sv
// -----------------------------------------------------------------------------
// bft_pkg
// Shared definitions for the BFT leaf packet format:
//   packet = {valid, dest addr, payload}
//   valid bit   : p_sz-1
//   dest addr   : [p_sz-2:payload_sz]
//   payload     : [payload_sz-1:0]
// -----------------------------------------------------------------------------
package bft_pkg;

    // Address width for a tree with n leaves; a one-leaf tree still gets a
    // one-bit field so that packed ranges stay legal.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full packet width: valid + address + payload.
    function automatic int pkt_w(input int n, input int payload);
        return 1 + addr_w(n) + payload;
    endfunction

    // Field offsets for a given packet geometry.
    function automatic int valid_bit(input int n, input int payload);
        return pkt_w(n, payload) - 1;
    endfunction

    function automatic int addr_lsb(input int payload);
        return payload;
    endfunction

endpackage

// File: rtl/pe_rx_fifo.sv
// -----------------------------------------------------------------------------
// pe_rx_fifo
// Synchronous FIFO, 2**ASIZE entries of DSIZE bits, head visible
// combinationally on rdata. A push into a full FIFO is accepted when a pop
// happens in the same cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only)
//   winc, wdata     push request and data
//   rinc            pop request (ignored when empty)
//   rdata           current head entry
//   wfull, rempty   status flags
// -----------------------------------------------------------------------------
module pe_rx_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    logic [DSIZE-1:0] mem [2**ASIZE];
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    // Extra MSB on each pointer distinguishes full from empty.
    assign rempty  = (wptr_q == rptr_q);
    assign wfull   = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                     (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    assign do_pop  = rinc && !rempty;
    // When full, the slot being written is the head being popped this cycle,
    // so overwriting it is safe.
    assign do_push = winc && (!wfull || do_pop);

    assign wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
    assign rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
    assign rdata   = mem[rptr_q[ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/pe_port.sv
// -----------------------------------------------------------------------------
// pe_port
// PE-side endpoint of a BFT leaf interface.
//   RX: unhandshaked packet pulses on interface_pe are buffered in a FIFO and
//       offered to the PE as rx_valid/rx_ready/rx_data. Packets arriving at a
//       full FIFO with no pop are dropped and counted.
//   TX: a one-entry hold register turns tx_valid/tx_ready into packets on
//       pe_interface, stalling while resend is high.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   interface_pe                       incoming packet (MSB = valid pulse)
//   pe_interface                       outgoing packet, zero when idle
//   resend                             downstream TX FIFO full
//   rx_valid, rx_ready, rx_data        RX stream to the PE
//   tx_valid, tx_ready, tx_dest,
//   tx_payload                         TX stream from the PE
//   rx_overflow                        sticky RX drop flag
//   drop_count                         saturating RX drop counter
//   self_tx                            sticky flag: PE sent to its own leaf
// -----------------------------------------------------------------------------
module pe_port
    import bft_pkg::*;
#(
    parameter int          num_leaves = 2,
    parameter int          payload_sz = 1,
    parameter int unsigned addr       = 0,
    parameter int          p_sz       = bft_pkg::pkt_w(num_leaves, payload_sz),
    parameter int          rx_asize   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [p_sz-1:0]                   interface_pe,
    output logic [p_sz-1:0]                   pe_interface,
    input  logic                              resend,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [payload_sz-1:0]             rx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic [addr_w(num_leaves)-1:0]     tx_dest,
    input  logic [payload_sz-1:0]             tx_payload,
    output logic                              rx_overflow,
    output logic [15:0]                       drop_count,
    output logic                              self_tx
);

    localparam int AW = addr_w(num_leaves);
    localparam logic [AW-1:0] SELF_ADDR = addr[AW-1:0];

    // ------------------------------------------------------------------ RX
    logic                  rx_push;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_drop;
    logic [payload_sz-1:0] rx_head;
    logic                  rx_overflow_q, rx_overflow_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic                  unused_rx_addr;

    // The address field was already filtered upstream.
    assign unused_rx_addr = ^interface_pe[p_sz-2:payload_sz];

    assign rx_push = interface_pe[p_sz-1];
    // Full implies non-empty, so rx_ready alone decides whether a pop frees
    // the slot this cycle.
    assign rx_drop = rx_push && rx_full && !rx_ready;

    pe_rx_fifo #(
        .DSIZE (payload_sz),
        .ASIZE (rx_asize)
    ) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .winc   (rx_push),
        .wdata  (interface_pe[payload_sz-1:0]),
        .rinc   (rx_ready),
        .rdata  (rx_head),
        .wfull  (rx_full),
        .rempty (rx_empty)
    );

    assign rx_valid = !rx_empty;
    // Stale memory contents are masked so the head reads zero when empty.
    assign rx_data  = rx_empty ? '0 : rx_head;

    assign rx_overflow_d = rx_overflow_q || rx_drop;
    assign drop_count_d  = (rx_drop && drop_count_q != 16'hFFFF) ?
                           drop_count_q + 16'd1 : drop_count_q;

    // ------------------------------------------------------------------ TX
    logic            hold_v_q, hold_v_d;
    logic [p_sz-1:0] hold_pkt_q, hold_pkt_d;
    logic            self_tx_q, self_tx_d;
    logic            tx_accept;
    logic            tx_consume;

    assign tx_ready   = !hold_v_q || !resend;
    assign tx_accept  = tx_valid && tx_ready;
    assign tx_consume = hold_v_q && !resend;

    // Combinational so the packet is withdrawn in the very cycle resend rises.
    assign pe_interface = tx_consume ? hold_pkt_q : '0;

    always_comb begin
        hold_v_d   = hold_v_q;
        hold_pkt_d = hold_pkt_q;
        self_tx_d  = self_tx_q;
        if (tx_accept) begin
            hold_v_d   = 1'b1;
            hold_pkt_d = {1'b1, tx_dest, tx_payload};
            if (tx_dest == SELF_ADDR) begin
                self_tx_d = 1'b1;
            end
        end else if (tx_consume) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q      <= 1'b0;
            hold_pkt_q    <= '0;
            self_tx_q     <= 1'b0;
            rx_overflow_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            hold_v_q      <= hold_v_d;
            hold_pkt_q    <= hold_pkt_d;
            self_tx_q     <= self_tx_d;
            rx_overflow_q <= rx_overflow_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign rx_overflow = rx_overflow_q;
    assign drop_count  = drop_count_q;
    assign self_tx     = self_tx_q;

endmodule

// File: tb/tb_pe_port.sv
// -----------------------------------------------------------------------------
// tb_pe_port
// Directed bench for pe_port with 4 leaves, 8-bit payload, 4-entry RX FIFO
// and leaf address 1. Inputs change 1 ns after the rising edge; outputs are
// checked in the same window.
// -----------------------------------------------------------------------------
module tb_pe_port;

    localparam int NL = 4;
    localparam int PL = 8;
    localparam int PS = 11;

    logic          clk;
    logic          rst_n;
    logic [PS-1:0] interface_pe;
    logic [PS-1:0] pe_interface;
    logic          resend;
    logic          rx_valid;
    logic          rx_ready;
    logic [PL-1:0] rx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [1:0]    tx_dest;
    logic [PL-1:0] tx_payload;
    logic          rx_overflow;
    logic [15:0]   drop_count;
    logic          self_tx;

    int tests_run;
    int tests_failed;

    pe_port #(
        .num_leaves (NL),
        .payload_sz (PL),
        .addr       (1),
        .p_sz       (PS),
        .rx_asize   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .interface_pe (interface_pe),
        .pe_interface (pe_interface),
        .resend       (resend),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_dest      (tx_dest),
        .tx_payload   (tx_payload),
        .rx_overflow  (rx_overflow),
        .drop_count   (drop_count),
        .self_tx      (self_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PS-1:0] pkt(input logic [1:0] d, input logic [7:0] p);
        return {1'b1, d, p};
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        interface_pe = '0;
        resend       = 1'b0;
        rx_ready     = 1'b0;
        tx_valid     = 1'b0;
        tx_dest      = '0;
        tx_payload   = '0;

        // ---------------------------------------------------- reset values
        #2;
        check("rst_pe_interface", 32'(pe_interface), 32'h0);
        check("rst_rx_valid",     32'(rx_valid),     32'h0);
        check("rst_rx_data",      32'(rx_data),      32'h0);
        check("rst_tx_ready",     32'(tx_ready),     32'h1);
        check("rst_drop_count",   32'(drop_count),   32'h0);
        check("rst_flags",        32'({rx_overflow, self_tx}), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // ---------------------------------------------------- RX burst
        for (int i = 0; i < 4; i++) begin
            interface_pe = pkt(2'd1, 8'(8'h11 * (i + 1)));
            step();
            if (i == 0) begin
                check("rx_latency_valid", 32'(rx_valid), 32'h1);
            end
        end
        interface_pe = '0;
        #1;
        check("rx_burst_valid", 32'(rx_valid), 32'h1);
        check("rx_burst_head",  32'(rx_data),  32'h11);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rx_burst_pop%0d", i), 32'(rx_data), 32'(8'h11 * (i + 1)));
            step();
        end
        check("rx_burst_drained", 32'(rx_valid), 32'h0);
        rx_ready = 1'b0;

        // ---------------------------------------------------- RX overflow
        for (int i = 0; i < 6; i++) begin
            interface_pe = pkt(2'd1, 8'(8'h50 + i));
            step();
        end
        interface_pe = '0;
        #1;
        check("ovf_flag",  32'(rx_overflow), 32'h1);
        check("ovf_count", 32'(drop_count),  32'h2);
        check("ovf_head",  32'(rx_data),     32'h50);
        // Full FIFO: push and pop in the same cycle, nothing dropped.
        interface_pe = pkt(2'd1, 8'h60);
        rx_ready     = 1'b1;
        step();
        interface_pe = '0;
        rx_ready     = 1'b0;
        #1;
        check("ovf_pushpop_count", 32'(drop_count), 32'h2);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("ovf_drain%0d", i), 32'(rx_data),
                  (i == 3) ? 32'h60 : 32'(8'h51 + i));
            step();
        end
        check("ovf_drained", 32'(rx_valid), 32'h0);
        rx_ready = 1'b0;

        // ---------------------------------------------------- TX streaming
        tx_dest  = 2'd3;
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_payload = 8'(8'hA0 + i);
            #1;
            check($sformatf("tx_stream_ready%0d", i), 32'(tx_ready), 32'h1);
            step();
            check($sformatf("tx_stream_pkt%0d", i), 32'(pe_interface),
                  32'(pkt(2'd3, 8'(8'hA0 + i))));
        end
        tx_valid = 1'b0;
        step();
        check("tx_stream_idle", 32'(pe_interface), 32'h0);

        // ---------------------------------------------------- TX backpressure
        tx_dest    = 2'd2;
        tx_payload = 8'hB5;
        tx_valid   = 1'b1;
        step();
        resend     = 1'b1;
        tx_payload = 8'hCC;     // offered during stall; must not replace B5
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_pe_interface%0d", i), 32'(pe_interface), 32'h0);
            check($sformatf("bp_tx_ready%0d", i),     32'(tx_ready),     32'h0);
            step();
        end
        resend   = 1'b0;
        tx_valid = 1'b0;
        #1;
        check("bp_release_pkt", 32'(pe_interface), 32'(pkt(2'd2, 8'hB5)));
        step();
        check("bp_sent_once", 32'(pe_interface), 32'h0);
        check("bp_no_self",   32'(self_tx),      32'h0);

        // ---------------------------------------------------- self address
        tx_dest    = 2'd1;
        tx_payload = 8'h77;
        tx_valid   = 1'b1;
        step();
        tx_valid = 1'b0;
        check("self_pkt",  32'(pe_interface), 32'(pkt(2'd1, 8'h77)));
        check("self_flag", 32'(self_tx),      32'h1);
        step();
        step();
        check("self_sticky", 32'(self_tx), 32'h1);

        // ---------------------------------------------------- reset mid-traffic
        for (int i = 0; i < 3; i++) begin
            interface_pe = pkt(2'd1, 8'(8'h90 + i));
            if (i == 2) begin
                tx_dest    = 2'd0;
                tx_payload = 8'h99;
                tx_valid   = 1'b1;
            end
            step();
        end
        interface_pe = '0;
        tx_valid     = 1'b0;
        resend       = 1'b1;
        #1;
        check("mid_pre_tx_ready", 32'(tx_ready), 32'h0);
        check("mid_pre_rx_valid", 32'(rx_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pe_interface", 32'(pe_interface), 32'h0);
        check("mid_rst_rx_valid",     32'(rx_valid),     32'h0);
        check("mid_rst_tx_ready",     32'(tx_ready),     32'h1);
        check("mid_rst_drop_count",   32'(drop_count),   32'h0);
        check("mid_rst_flags",        32'({rx_overflow, self_tx}), 32'h0);
        step();
        rst_n  = 1'b1;
        resend = 1'b0;
        #1;
        check("mid_post_no_tx", 32'(pe_interface), 32'h0);
        step();
        check("mid_post_rx_empty", 32'(rx_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pe_port.md
Name: pe_port

Overview:
- PE-side endpoint of the BFT leaf `interface` block, connecting one processing element to its leaf.
- RX: converts the unhandshaked packet stream on interface_pe into a buffered valid/ready stream for the PE.
- TX: converts a valid/ready stream from the PE into the packets `interface` injects on pe_interface, and honours its resend (TX FIFO full) backpressure.
- Instantiated once per leaf, between the PE and `interface`.

Parameters:
- num_leaves, 2, number of BFT leaves; address width is $clog2(num_leaves).
- payload_sz, 1, payload bits per packet.
- addr, 1'b0, this leaf's address; used only for the self-address check.
- p_sz, 1+$clog2(num_leaves)+payload_sz, packet width: {valid, dest addr, payload}.
- rx_asize, 2, RX FIFO depth is 2**rx_asize entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- interface_pe  in  p_sz  packet from `interface`; bit p_sz-1 is valid; one-cycle pulse; no backpressure possible.
- pe_interface  out  p_sz  packet to `interface`; all-zero when idle.
- resend  in  1  `interface` TX FIFO full; while high, a write would be lost.
- rx_valid  out  1  RX payload available.
- rx_ready  in  1  PE consumes RX payload.
- rx_data  out  payload_sz  RX payload (FIFO head).
- tx_valid  in  1  PE offers a packet.
- tx_ready  out  1  pe_port accepts the TX offer this cycle.
- tx_dest  in  $clog2(num_leaves)  destination leaf.
- tx_payload  in  payload_sz  TX payload.
- rx_overflow  out  1  sticky: an RX packet was dropped.
- drop_count  out  16  saturating count of dropped RX packets.
- self_tx  out  1  sticky: a TX packet was addressed to addr.

Behaviour:
Reset:
- rst_n low clears, asynchronously, all state and outputs: pe_interface=0, rx_valid=0, rx_data=0, tx_ready=1 (combinational from empty hold), flags 0, drop_count=0.
- Reset mid-operation discards RX FIFO contents and any held TX packet.

RX path:
- On a clk edge with interface_pe[p_sz-1]=1, write interface_pe[payload_sz-1:0] into the RX FIFO.
- The address field is not checked; `interface` has already filtered it.
- rx_valid = FIFO not empty; rx_data = head, driven combinationally from the FIFO memory.
- Pop on rx_valid && rx_ready.
- Latency: a packet arriving at edge N is visible at rx_valid after edge N, one cycle.
- Full FIFO, incoming packet, no pop in the same cycle: drop the packet, set rx_overflow, increment drop_count (saturates at 16'hFFFF).
- Full FIFO with a simultaneous pop and push: the push succeeds, no drop.
- Empty FIFO with a simultaneous push: rx_valid rises next cycle; no bypass.
- Pointers are rx_asize+1 bits and wrap modulo 2**(rx_asize+1).

TX path:
- Single-entry hold register: hold_v, hold_pkt.
- tx_ready = !hold_v || !resend.
- Accept on tx_valid && tx_ready: hold_pkt <= {1'b1, tx_dest, tx_payload}, hold_v <= 1.
- pe_interface = (hold_v && !resend) ? hold_pkt : 0, combinational so that resend is sampled in the same cycle `interface` writes.
- Consume: hold_v && !resend at an edge; hold_v clears unless a new accept happens at the same edge.
- Throughput: 1 packet/cycle while resend=0. Latency: accept at edge N, presented after N, written at edge N+1.
- While resend=1: hold_pkt is frozen, pe_interface=0, and a new offer is accepted only if hold_v=0.
- tx_dest==addr: the packet is still sent, and self_tx is set.

Decomposition:
- Shared package bft_pkg: address width function ($clog2(num_leaves)), p_sz derivation, field offsets (valid bit p_sz-1, address [p_sz-2:payload_sz], payload [payload_sz-1:0]).
- One sub-module: pe_rx_fifo, a synchronous FIFO (DSIZE=payload_sz, ASIZE=rx_asize) with async active-low reset, rdata/rempty/wfull, and simultaneous push/pop allowed when full.

Test Plan:
- Reset: hold rst_n=0 mid-traffic with 3 RX entries queued and hold_v=1 -> pe_interface=0, rx_valid=0, tx_ready=1 immediately (asynchronous), drop_count=0.
- RX burst: num_leaves=4, payload_sz=8, rx_asize=2; 4 pulses payload 0x11..0x44, rx_ready=0 -> rx_valid=1, rx_data=0x11; then rx_ready=1 -> 0x11,0x22,0x33,0x44 on consecutive cycles.
- RX overflow: 6 packets into the full FIFO, rx_ready=0 -> 4 stored, rx_overflow=1, drop_count=2; full-FIFO push with a simultaneous pop -> no drop.
- TX streaming: tx_valid held 5 cycles, dest=2'd3, payload 0xA0..0xA4, resend=0 -> pe_interface shows {1,3,0xA0}..{1,3,0xA4} one cycle after each accept, with no gaps.
- TX backpressure: resend=1 for 3 cycles with hold_v=1 -> pe_interface=0, tx_ready=0, held packet unchanged; resend=0 -> packet sent exactly once, no duplicate or loss.
- Self address: tx_dest==addr -> packet emitted, self_tx=1, and it stays set.
